// File: rtl/shift_sequencer_pkg.sv
// Shared defaults, FSM state encoding and command-entry layout for the shift sequencer.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LD   = 2'd1,
    SH   = 2'd2,
    DN   = 2'd3
  } state_e;

  // Field order of one queued command, most significant field first.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic                 dir;
    logic                 fill;
    logic [DEF_CNT_W-1:0] cnt;
  } cmd_entry_t;

  localparam int ENTRY_W = $bits(cmd_entry_t);

endpackage

// File: rtl/shift_sequencer_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and an occupancy count.
module cmd_fifo #(
  parameter int DW    = 14,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DW-1:0]          wdata_i,
  output logic [DW-1:0]          rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          wr_en;
  logic          rd_en;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Queues shift commands and sequences load/shift/done strobes for a downstream shift register.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [WIDTH-1:0]       cmd_data_i,
  input  logic                   cmd_dir_i,
  input  logic                   cmd_fill_i,
  input  logic [CNT_W-1:0]       cmd_cnt_i,
  output logic                   load_o,
  output logic                   shift_o,
  output logic                   dir_o,
  output logic                   ser_in_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [$clog2(DEPTH):0] level_o
);

  // Same field order as cmd_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             dir;
    logic             fill;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t           wr_entry;
  entry_t           rd_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  state_e           state_q;
  logic             load_q;
  logic             shift_q;
  logic             done_q;
  logic             busy_q;
  logic             dir_q;
  logic             ser_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;

  assign wr_entry    = {cmd_data_i, cmd_dir_i, cmd_fill_i, cmd_cnt_i};
  assign push        = cmd_valid_i && !fifo_full;
  assign pop         = ((state_q == IDLE) || (state_q == DN)) && !fifo_empty;
  assign cmd_ready_o = !fifo_full;

  cmd_fifo #(
    .DW    ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  // Strobes are set alongside the transition into the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dir_q   <= 1'b0;
      ser_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE, DN: begin
          if (!fifo_empty) begin
            data_q  <= rd_entry.data;
            dir_q   <= rd_entry.dir;
            ser_q   <= rd_entry.fill;
            cnt_q   <= rd_entry.cnt;
            state_q <= LD;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        LD: begin
          if (cnt_q != '0) begin
            state_q <= SH;
            shift_q <= 1'b1;
          end else begin
            state_q <= DN;
            done_q  <= 1'b1;
          end
        end
        SH: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DN;
            done_q  <= 1'b1;
          end else begin
            shift_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_o   = load_q;
  assign shift_o  = shift_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;
  assign dir_o    = dir_q;
  assign ser_in_o = ser_q;
  assign data_o   = data_q;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, 8: width of the command data word and the DATA output.
REQ-002 Parameter DEPTH, 4: number of entries in the command FIFO; power of two, at least 2.
REQ-003 Parameter CNT_W, 4: width of the shift-count field.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset; synchronous and active-high.
REQ-006 CMD_VALID  input  1  command present on the CMD_* inputs.
REQ-007 CMD_READY  output  1  FIFO can accept a command; high exactly when the FIFO is not full (registered).
REQ-008 CMD_DATA  input  WIDTH  parallel word to load.
REQ-009 CMD_DIR  input  1  shift direction; 1 = left, 0 = right.
REQ-010 CMD_FILL  input  1  serial fill bit applied during shifts.
REQ-011 CMD_CNT  input  CNT_W  number of shift cycles, 0..15.
REQ-012 LOAD  output  1  load strobe to the downstream shift register.
REQ-013 SHIFT  output  1  shift-enable to the downstream shift register.
REQ-014 DIR  output  1  direction to the downstream shift register.
REQ-015 SER_IN  output  1  serial fill bit to the downstream shift register.
REQ-016 DATA  output  WIDTH  parallel load word to the downstream shift register.
REQ-017 BUSY  output  1  high in every state except IDLE.
REQ-018 DONE  output  1  one-cycle pulse at command completion.
REQ-019 LEVEL  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-020 A command is accepted on a rising edge when CMD_VALID and CMD_READY are both high; it is written to the FIFO with fields {DATA, DIR, FILL, CNT}.
REQ-021 All outputs are registered; no output depends combinationally on any input.
REQ-022 The FSM states are IDLE, LD, SH and DN.
REQ-023 IDLE: when the FIFO is non-empty, pop the head entry, latch its fields into the DATA/DIR/SER_IN/count registers, and go to LD.
REQ-024 LD: LOAD=1 and SHIFT=0 for exactly one cycle; next state is SH if CNT>0, otherwise DN.
REQ-025 SH: SHIFT=1 and LOAD=0 for exactly CNT consecutive cycles, with a down-counter; DN is entered after the last shift cycle.
REQ-026 DN: DONE=1 for one cycle; if the FIFO is non-empty, pop and go to LD, otherwise go to IDLE.
REQ-027 Latency: a command accepted at the edge ending cycle t into an empty, idle block produces LOAD in cycle t+2, SHIFT in cycles t+3..t+2+CNT, and DONE in cycle t+3+CNT.
REQ-028 Back-to-back: the LOAD of the next queued command occurs in the cycle immediately after DN.
REQ-029 LOAD and SHIFT are never high in the same cycle.
REQ-030 DATA, DIR and SER_IN hold the current command's values from LD through DN, and hold them in IDLE until the next pop.
REQ-031 A push and a pop in the same cycle leave LEVEL unchanged.
REQ-032 When the FIFO is full, CMD_READY=0 and CMD_VALID is ignored, even if a pop occurs in the same cycle.
REQ-033 FIFO read and write pointers wrap modulo DEPTH; LEVEL ranges 0..DEPTH.

Reset
REQ-034 While RST=1 at an edge: FSM goes to IDLE; FIFO is emptied (LEVEL=0); LOAD, SHIFT, DIR, SER_IN, DONE, BUSY=0; DATA=0; CMD_READY=1 on the following cycle.
REQ-035 Reset asserted mid-command aborts it with no DONE, and a command presented during reset is not accepted.

Structure
REQ-036 Package shift_seq_pkg holds WIDTH, DEPTH and CNT_W defaults, the FSM state encoding and the command-entry field layout.
REQ-037 The FIFO is a sub-module named cmd_fifo: synchronous, with full/empty flags and level output, reset by RST.

Verification
REQ-038 Reset then one command {DATA=8'h55, DIR=1, FILL=0, CNT=8}: LOAD one cycle with DATA=8'h55, SHIFT 8 cycles with DIR=1 and SER_IN=0, DONE one cycle, BUSY falls afterwards.
REQ-039 Command with CNT=0 and DATA=8'hFF: LOAD in one cycle, DONE in the next, SHIFT never asserted.
REQ-040 Push 5 commands back-to-back while the first executes: CMD_READY drops once LEVEL reaches 4, and the LOAD for each queued command follows its predecessor's DONE by one cycle.
REQ-041 Push while popping at LEVEL=2: LEVEL stays 2, and the command order is preserved (DATA 8'h01, 8'h02, 8'h03 in sequence).
REQ-042 RST pulsed during the 3rd SHIFT cycle of a CNT=8 command with LEVEL=2: SHIFT=0 next cycle, no DONE, LEVEL=0, and the FSM is IDLE.
REQ-043 Right shift {DATA=8'hFF, DIR=0, FILL=1, CNT=3}: three SHIFT cycles with DIR=0 and SER_IN=1, and the downstream shift register model reads 8'hFF.
